// File: rtl/q2_pkg.sv
// Shared definitions for the Q2 bit-serial ALU sequencer.
//   OP_*      : two-bit operation encodings presented on op / latched for RUN
//   state_e   : sequencer states
//   DEFAULT_WIDTH : datapath word width used when the top is not overridden
package q2_pkg;

    localparam int DEFAULT_WIDTH = 12;

    localparam logic [1:0] OP_LOAD = 2'b00;  // A <= X
    localparam logic [1:0] OP_NOR  = 2'b01;  // A <= ~(A | X)
    localparam logic [1:0] OP_ADD  = 2'b10;  // A <= A + X + F
    localparam logic [1:0] OP_SHR  = 2'b11;  // A <= {F, X[W-1:1]}

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_serial_ctrl_alu.sv
// One-bit ALU slice used by the Q2 serial sequencer.
// Ports:
//   o0, no0, o1, no1 : dual-rail operation select (o1/o0 = op[1]/op[0])
//   a0, x0           : current LSBs of A and X
//   x1               : next-higher X bit (or F on the last bit, for SHR)
//   f                : carry / flag input
//   alu_out          : result bit shifted into the top of A
//   alu_ncout        : inverted carry-out; the sequencer stores ~alu_ncout in F
// Only ADD produces a new carry; all other operations pass F through.
module alu (
    input  logic o0,
    input  logic no0,
    input  logic o1,
    input  logic no1,
    input  logic a0,
    input  logic x0,
    input  logic x1,
    input  logic f,
    output logic alu_out,
    output logic alu_ncout
);

    logic sel_load;
    logic sel_nor;
    logic sel_add;
    logic sel_shr;
    logic sum;
    logic cout;

    // Both rails are used so each select term is a simple two-input AND.
    assign sel_load = no1 & no0;
    assign sel_nor  = no1 & o0;
    assign sel_add  = o1  & no0;
    assign sel_shr  = o1  & o0;

    assign sum  = a0 ^ x0 ^ f;
    assign cout = (a0 & x0) | (f & (a0 ^ x0));

    assign alu_out = (sel_load & x0)
                   | (sel_nor  & ~(a0 | x0))
                   | (sel_add  & sum)
                   | (sel_shr  & x1);

    assign alu_ncout = sel_add ? ~cout : ~f;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer for the Q2 datapath.
// Holds the accumulator A, operand X and flag F, and steps the one-bit
// alu slice through WIDTH cycles per operation, LSB first.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   a_load/a_in            : parallel load of A (IDLE only)
//   x_load/x_in            : parallel load of X (IDLE only)
//   f_set/f_in             : load of F (IDLE only)
//   start/op               : begin operation op (IDLE only)
//   a_q, x_q, carry        : registered A, X, F (valid in IDLE and DONE)
//   busy                   : high in every RUN cycle
//   done                   : one-cycle completion pulse (DONE state)
//
// state | meaning
// IDLE  | accepts loads and start
// RUN   | one bit per cycle, count 0..WIDTH-1
// DONE  | completion pulse, returns to IDLE next cycle
module alu_serial_ctrl
    import q2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_load,
    input  logic [WIDTH-1:0] a_in,
    input  logic             x_load,
    input  logic [WIDTH-1:0] x_in,
    input  logic             f_set,
    input  logic             f_in,
    input  logic             start,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] x_q,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] x_d;
    logic             f_q,     f_d;

    logic last_bit;
    logic slice_x1;
    logic alu_out;
    logic alu_ncout;

    assign last_bit = (cnt_q == CNT_LAST);

    // On the final bit the slice sees F as the "next" X bit so SHR fills
    // the MSB of A with F.
    assign slice_x1 = last_bit ? f_q : x_q[1];

    alu u_alu (
        .o0        (op_q[0]),
        .no0       (~op_q[0]),
        .o1        (op_q[1]),
        .no1       (~op_q[1]),
        .a0        (a_q[0]),
        .x0        (x_q[0]),
        .x1        (slice_x1),
        .f         (f_q),
        .alu_out   (alu_out),
        .alu_ncout (alu_ncout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        x_d     = x_q;
        f_d     = f_q;

        case (state_q)
            IDLE: begin
                // Loads land at the same edge that accepts start, so RUN
                // begins on the freshly loaded values.
                if (a_load) a_d = a_in;
                if (x_load) x_d = x_in;
                if (f_set)  f_d = f_in;
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d = {alu_out, a_q[WIDTH-1:1]};
                // X rotates rather than shifts so it is intact after WIDTH bits.
                x_d = {x_q[0], x_q[WIDTH-1:1]};
                f_d = ~alu_ncout;
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            a_q     <= '0;
            x_q     <= '0;
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            x_q     <= x_d;
            f_q     <= f_d;
        end
    end

    assign carry = f_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;
    import q2_pkg::*;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         a_load;
    logic [W-1:0] a_in;
    logic         x_load;
    logic [W-1:0] x_in;
    logic         f_set;
    logic         f_in;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_q;
    logic [W-1:0] x_q;
    logic         carry;
    logic         busy;
    logic         done;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_load (a_load),
        .a_in   (a_in),
        .x_load (x_load),
        .x_in   (x_in),
        .f_set  (f_set),
        .f_in   (f_in),
        .start  (start),
        .op     (op),
        .a_q    (a_q),
        .x_q    (x_q),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] x;
        logic         f;
    } exp_t;

    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    logic rst_chk = 1'b0;
    logic end_req = 1'b0;

    // Only the monitor calls this, so the counters have a single writer.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    initial begin : monitor
        int   busy_cnt;
        logic prev_done;
        logic end_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        end_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("done_pulse_width", {31'b0, done}, 32'd0);
                if (busy) busy_cnt++;
                if (done) begin
                    chk("busy_cycles", busy_cnt, W);
                    chk("busy_in_done", {31'b0, busy}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_a", {20'b0, a_q}, {20'b0, e.a});
                        chk("result_x", {20'b0, x_q}, {20'b0, e.x});
                        chk("result_f", {31'b0, carry}, {31'b0, e.f});
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
                if (rst_chk) begin
                    chk("rst_a",    {20'b0, a_q}, 32'd0);
                    chk("rst_x",    {20'b0, x_q}, 32'd0);
                    chk("rst_f",    {31'b0, carry}, 32'd0);
                    chk("rst_busy", {31'b0, busy}, 32'd0);
                    chk("rst_done", {31'b0, done}, 32'd0);
                end
                if (end_req && !end_done) begin
                    chk("pending_results", exp_q.size(), 32'd0);
                    end_done = 1'b1;
                end
            end
        end
    end

    task automatic idle_inputs();
        a_load = 1'b0; x_load = 1'b0; f_set = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int inject_k, input int reset_k);
        int i;
        for (i = 0; i < 40; i++) begin
            if (done) break;
            if (i == inject_k) begin
                start = 1'b1; op = OP_NOR; a_load = 1'b1; a_in = 12'hFFF;
            end else if (i == inject_k + 1) begin
                idle_inputs();
            end
            if (i == reset_k) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
            $fatal(1, "timeout");
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    // Load A/X/F, then start op (same cycle when same=1); push expectation.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] x,
                          input logic f, input bit same,
                          input logic [W-1:0] ea, input logic [W-1:0] ex, input logic ef,
                          input int inject_k);
        exp_t e;
        a_load = 1'b1; a_in = a; x_load = 1'b1; x_in = x; f_set = 1'b1; f_in = f;
        if (same) begin start = 1'b1; op = o; end
        @(posedge clk); #1;
        idle_inputs();
        if (!same) begin
            start = 1'b1; op = o;
            @(posedge clk); #1;
            start = 1'b0;
        end
        e.a = ea; e.x = ex; e.f = ef;
        exp_q.push_back(e);
        wait_done(inject_k, -1);
    endtask

    initial begin
        rst = 1'b1; a_in = '0; x_in = '0; f_in = 1'b0; op = 2'b00;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rst_chk = 1'b1;
        @(posedge clk); #1 rst_chk = 1'b0;

        //      op       A        X        F     same  expA     expX     expF  inject
        run_op(OP_ADD,  12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 12'h001, 1'b0, -1);
        run_op(OP_ADD,  12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 12'h001, 1'b1, -1);
        run_op(OP_ADD,  12'h000, 12'h000, 1'b1, 1'b0, 12'h001, 12'h000, 1'b0, -1);
        run_op(OP_NOR,  12'hF0F, 12'h0F0, 1'b0, 1'b0, 12'h000, 12'h0F0, 1'b0, -1);
        run_op(OP_NOR,  12'h000, 12'h000, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, -1);
        run_op(OP_LOAD, 12'h123, 12'hABC, 1'b0, 1'b0, 12'hABC, 12'hABC, 1'b0, -1);
        run_op(OP_SHR,  12'h555, 12'h003, 1'b1, 1'b0, 12'h801, 12'h003, 1'b1, -1);
        run_op(OP_SHR,  12'h555, 12'h002, 1'b0, 1'b0, 12'h001, 12'h002, 1'b0, -1);
        // start + a_load during k=5 must be dropped
        run_op(OP_ADD,  12'h100, 12'h023, 1'b0, 1'b0, 12'h123, 12'h023, 1'b0, 5);
        // load and start in the same IDLE cycle
        run_op(OP_ADD,  12'h0F0, 12'h00F, 1'b1, 1'b1, 12'h100, 12'h00F, 1'b0, -1);

        // Reset at k=6 of an ADD: no result is expected from the aborted op.
        a_load = 1'b1; a_in = 12'h123; x_load = 1'b1; x_in = 12'h456; f_set = 1'b1; f_in = 1'b1;
        start = 1'b1; op = OP_ADD;
        @(posedge clk); #1;
        idle_inputs();
        wait_done(-10, 6);
        rst_chk = 1'b1;
        @(posedge clk); #1 rst_chk = 1'b0;

        run_op(OP_ADD,  12'h005, 12'h003, 1'b0, 1'b0, 12'h008, 12'h003, 1'b0, -1);

        repeat (3) @(posedge clk);
        #1 end_req = 1'b1;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer for the Q2 datapath.
- Holds the WIDTH-bit accumulator (A) and operand (X) shift registers and the carry flag F.
- Drives the one-bit alu slice (o0/no0/o1/no1 select, a0/x0/x1/f) for WIDTH consecutive cycles per operation, LSB first, then reports completion.
- Sits between the instruction decoder (start/op handshake) and the register file (parallel load/readback).

Parameters:
- WIDTH, 12, data word width in bits; also the number of bit cycles per operation (must be >= 2).
- CW, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  in  1  single system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- a_load  in  1  parallel load A from a_in (IDLE only)
- a_in  in  WIDTH  A load value
- x_load  in  1  parallel load X from x_in (IDLE only)
- x_in  in  WIDTH  X load value
- f_set  in  1  set F to f_in (IDLE only)
- f_in  in  1  F load value
- start  in  1  begin operation op (IDLE only)
- op  in  2  00 LOAD (A<=X), 01 NOR (A<=~(A|X)), 10 ADD (A<=A+X+F), 11 SHR (A<={F,X[W-1:1]})
- a_q  out  WIDTH  accumulator contents
- x_q  out  WIDTH  operand contents
- carry  out  1  F
- busy  out  1  high during bit cycles
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: A=0, X=0, F=0, state IDLE, bit count 0, op latch 00, busy=0, done=0. Reset mid-operation aborts immediately; no partial result is retained.
- States: IDLE -> RUN (on start) -> DONE (after bit WIDTH-1) -> IDLE (unconditionally, next cycle).
- IDLE:
  - a_load, x_load and f_set each update their register at the clock edge; they may be asserted together.
  - start latches op, clears the bit count and enters RUN at the next cycle.
  - If a load and start are asserted in the same cycle, the load is applied first, so RUN operates on the loaded values.
- RUN, one bit per cycle (count k = 0..WIDTH-1):
  - Slice inputs: a0 = A[0], x0 = X[0], f = F.
  - x1 = X[1] for k < WIDTH-1; x1 = F for k = WIDTH-1.
  - Select lines decoded from the latched op: o1 = op[1], no1 = ~op[1], o0 = op[0], no0 = ~op[0]. They are held constant for the whole RUN phase.
  - At each edge:
    - A <= {alu_out, A[W-1:1]}
    - X <= {X[0], X[W-1:1]} (rotate, so X is restored after WIDTH cycles)
    - F <= ~alu_ncout
    - count increments
  - F carry semantics are entirely those of the slice: ADD ripples the carry; SHR leaves F unchanged.
  - busy = 1 in every RUN cycle.
- Latency: start sampled in cycle T; RUN occupies cycles T+1..T+WIDTH; DONE occurs in cycle T+WIDTH+1 with done = 1 and busy = 0. start is accepted again from T+WIDTH+2 (IDLE).
- While in RUN or DONE, start, a_load, x_load and f_set are ignored (dropped, not queued).
- a_q, x_q and carry are registered outputs. During RUN they show the intermediate rotating state; they are valid only in DONE and IDLE.
- The bit count wraps at WIDTH-1 (RUN -> DONE); no count value >= WIDTH is ever used.
- An unknown op cannot occur: all 4 encodings are defined.

Decomposition:
- Shared package q2_pkg holds:
  - op encodings OP_LOAD/OP_NOR/OP_ADD/OP_SHR
  - state enum IDLE/RUN/DONE
  - default WIDTH = 12
- One sub-module: the existing one-bit alu slice (module alu), instantiated once. All sequencing, shift registers and the F register live in alu_serial_ctrl.

Test Plan:
- ADD: A=0x7FF, X=0x001, F=0, start -> after 12 RUN cycles, done pulse; A=0x800, F=0, X=0x001.
- ADD overflow: A=0xFFF, X=0x001, F=0 -> A=0x000, F=1. Repeat with A=0x000, X=0x000, F=1 -> A=0x001, F=0.
- NOR/LOAD:
  - NOR with A=0xF0F, X=0x0F0 -> A=0x000.
  - NOR with A=0x000, X=0x000 -> A=0xFFF.
  - LOAD with X=0xABC -> A=0xABC, X unchanged.
- SHR: X=0x003, F=1 -> A=0x801, F=1. SHR with X=0x002, F=0 -> A=0x001.
- Handshake:
  - busy high for exactly 12 cycles; done is a 1-cycle pulse.
  - start and a_load asserted at k=5 are ignored, and the result is unaffected.
  - Load+start in the same IDLE cycle uses the loaded values.
- Reset at k=6 of an ADD -> next cycle A=0, X=0, F=0, busy=0, done=0, IDLE. A subsequent op executes normally.
